// File: rtl/serial_adder_ctrl.sv
// Bit-serial add controller: one shared full-adder stage, WIDTH cycles per add.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUBTRACT_EN.

module half_adder (
  input  logic x_i,
  input  logic y_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = x_i ^ y_i;
  assign c_o = x_i & y_i;
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUBTRACT_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  logic [WIDTH-1:0] psum_q;
  logic [WIDTH-1:0] psum_d;
  logic [WIDTH-1:0] sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             carry_d;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;

  logic             hs0;
  logic             hc0;
  logic             hc1;
  logic             bit_w;

  logic [WIDTH-1:0] b_ld;
  logic             cin_ld;

`ifdef SERIAL_ADDER_SUBTRACT_EN
  // Subtraction is a + ~b + 1 through the same adder.
  assign b_ld   = sub ? ~b : b;
  assign cin_ld = sub;
`else
  assign b_ld   = b;
  assign cin_ld = 1'b0;
`endif

  half_adder u_ha0 (
    .x_i (a_sr_q[0]),
    .y_i (b_sr_q[0]),
    .s_o (hs0),
    .c_o (hc0)
  );

  half_adder u_ha1 (
    .x_i (hs0),
    .y_i (carry_q),
    .s_o (bit_w),
    .c_o (hc1)
  );

  assign carry_d = hc0 | hc1;

  // New sum bit enters at the MSB so the LSB ends up at bit 0.
  generate
    if (WIDTH == 1) begin : g_w1
      assign psum_d = bit_w;
    end else begin : g_wn
      assign psum_d = {bit_w, psum_q[WIDTH-1:1]};
    end
  endgenerate

  // Controller FSM with datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      psum_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_sr_q  <= a;
            b_sr_q  <= b_ld;
            carry_q <= cin_ld;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_sr_q  <= a_sr_q >> 1;
          b_sr_q  <= b_sr_q >> 1;
          psum_q  <= psum_d;
          carry_q <= carry_d;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            sum_q   <= psum_d;
            cout_q  <= carry_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH = 4).
// Model tracks elapsed cycles since acceptance and computes results arithmetically.

module tb_serial_adder_ctrl;

  localparam int W = 4;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_SUBTRACT_EN
  logic         sub;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef SERIAL_ADDER_SUBTRACT_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  // Reference model: age = cycles since acceptance (0 = idle).
  int  age = 0;
  int  opa = 0;
  int  opb = 0;
  int  osub = 0;
  int  esum = 0;
  int  ecout = 0;
  bit  chk_en = 0;

  always @(posedge clk) begin
    int full;
    if (reset) begin
      age = 0;
      esum = 0;
      ecout = 0;
      chk_en = 1;
    end else if (age == 0) begin
      if (start) begin
        age = 1;
        opa = int'(a);
        opb = int'(b);
        osub = 0;
`ifdef SERIAL_ADDER_SUBTRACT_EN
        osub = int'(sub);
`endif
      end
    end else if (age < W) begin
      age = age + 1;
    end else if (age == W) begin
      if (osub != 0)
        full = opa + ((~opb) & MASK) + 1;
      else
        full = opa + opb;
      esum = full & MASK;
      ecout = (full >> W) & 1;
      age = W + 1;
    end else begin
      age = 0;
    end
  end

  // Cycle-by-cycle compare against the model.
  always @(negedge clk) begin
    logic eb;
    logic ed;
    if (chk_en) begin
      eb = (age >= 1) && (age <= W);
      ed = (age == W + 1);
      n_cmp = n_cmp + 1;
      if (busy !== eb || done !== ed ||
          sum !== W'(esum) || cout !== 1'(ecout)) begin
        n_bad = n_bad + 1;
        $display("FAIL model: busy=%b done=%b sum=%0d cout=%b required busy=%b done=%b sum=%0d cout=%b",
                 busy, done, sum, cout, eb, ed, esum, ecout);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int req);
    n_cmp = n_cmp + 1;
    if (act !== req) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0d required %0d", nm, act, req);
    end
  endtask

  // Wait (bounded) for done; return busy cycle count seen and check result.
  task automatic wait_done(input string nm, input int es, input int ec,
                           output int nbusy);
    int k;
    nbusy = 0;
    k = 0;
    while (done !== 1'b1 && k < 30) begin
      if (busy === 1'b1) nbusy = nbusy + 1;
      @(negedge clk);
      k = k + 1;
    end
    chk({nm, "_seen"}, int'(done === 1'b1), 1);
    chk({nm, "_sum"}, int'(sum), es);
    chk({nm, "_cout"}, int'(cout), ec);
  endtask

  task automatic go(input int va, input int vb);
    a = W'(va);
    b = W'(vb);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int nb;
    int t0;
    int t1;
    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
`ifdef SERIAL_ADDER_SUBTRACT_EN
    sub = 1'b0;
`endif
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // 1: idle after reset
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_busy", int'(busy), 0);
      chk("idle_done", int'(done), 0);
      chk("idle_sum", int'(sum), 0);
    end

    // 2: 3 + 5
    go(3, 5);
    wait_done("add3_5", 8, 0, nb);
    chk("add3_5_busycnt", nb, 4);
    repeat (10) @(negedge clk);
    chk("add3_5_hold", int'(sum), 8);

    // 3: wrap-around
    go(15, 1);
    wait_done("add15_1", 0, 1, nb);
    @(negedge clk);
    go(15, 15);
    wait_done("add15_15", 14, 1, nb);
    @(negedge clk);

    // 4: start during RUN ignored
    go(2, 2);
    a = 4'd7;
    b = 4'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignore", 4, 0, nb);
    repeat (8) @(negedge clk);
    chk("no_second", int'(busy), 0);

    // 4b: start held high
    a = 4'd1;
    b = 4'd6;
    start = 1'b1;
    wait_done("held1", 7, 0, nb);
    t0 = $time;
    @(negedge clk);
    wait_done("held2", 7, 0, nb);
    t1 = $time;
    chk("held_period", (t1 - t0) / 10, W + 2);
    start = 1'b0;
    repeat (8) @(negedge clk);

    // 5: reset mid-RUN
    go(9, 4);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_sum", int'(sum), 0);
    repeat (6) begin
      @(negedge clk);
      chk("abort_nodone", int'(done), 0);
    end
    go(9, 4);
    wait_done("add9_4", 13, 0, nb);
    @(negedge clk);

`ifdef SERIAL_ADDER_SUBTRACT_EN
    // 6: subtract mode
    sub = 1'b1;
    go(5, 7);
    wait_done("sub5_7", 14, 0, nb);
    @(negedge clk);
    go(7, 5);
    wait_done("sub7_5", 2, 1, nb);
    @(negedge clk);
    sub = 1'b0;
    go(7, 5);
    wait_done("add7_5", 12, 0, nb);
    @(negedge clk);
`endif

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial add controller. Sequences one shared full-adder stage, built from two half_adder instances plus an OR on the carries, over WIDTH clock cycles to add two WIDTH-bit operands.
- Uses a start/busy/done handshake and holds its result.
- Sits between board switches/buttons and display logic in the lab top level. Trades area for latency versus a ripple adder.

Parameters:
WIDTH, 4, operand/result width in bits; legal range WIDTH >= 1.

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  synchronous, active-high reset
start  input  1  request a new operation; sampled only in IDLE
a  input  WIDTH  operand A; captured on the edge that accepts start
b  input  WIDTH  operand B; captured on the edge that accepts start
busy  output  1  high while state is RUN
done  output  1  one-cycle pulse; high while state is DONE
sum  output  WIDTH  registered result (sum/difference bits)
cout  output  1  registered carry-out of the MSB stage

Behaviour:
- Single clock domain (clk). Reset is synchronous and active-high; reset has priority over every other input.
- Reset values:
  - state = IDLE
  - busy = 0, done = 0, sum = 0, cout = 0
  - internal operand shift registers, partial-sum register, carry flop and bit counter = 0
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - busy = 0, done = 0.
  - If start = 1 at a rising edge: load a_sr <= a, b_sr <= b, carry <= 0 (see optional feature), cnt <= 0, go to RUN.
  - Otherwise stay in IDLE.
- RUN (busy = 1): each edge does all of the following.
  - bit = a_sr[0] ^ b_sr[0] ^ carry, computed through the two half_adder instances.
  - carry <= majority(a_sr[0], b_sr[0], carry).
  - Partial-sum register shifts right with bit entering at the MSB.
  - a_sr and b_sr shift right with 0 fill.
  - cnt <= cnt + 1.
  - On the edge where cnt == WIDTH-1: load sum <= final shifted value, cout <= new carry, go to DONE.
- DONE (done = 1, busy = 0): lasts exactly one cycle, then unconditionally returns to IDLE.
- Latency:
  - The start-accepting edge is E0. busy is high for exactly WIDTH cycles, after edges E0..E(WIDTH-1).
  - sum/cout update and done goes high after edge E(WIDTH).
  - Next start can be accepted at edge E(WIDTH+2).
- sum/cout are written only on the RUN->DONE transition. They hold their value through IDLE and through the following RUN until that operation completes.
- start during RUN or DONE: ignored, not queued.
- start held high continuously: back-to-back operations, each accepted on the first IDLE edge. a/b are re-sampled at each acceptance.
- a/b changing during RUN: no effect; operands are captured at acceptance.
- Width rules:
  - cnt is $clog2(WIDTH+1) bits wide.
  - Result is modulo 2^WIDTH; overflow is reported only via cout.
  - For WIDTH = 1: RUN lasts one cycle.
- Reset mid-RUN or mid-DONE: operation aborted, no done pulse, sum/cout forced to 0. The next start after reset behaves normally.
- Reset and start high on the same edge: reset wins and the FSM stays in IDLE.

Optional Feature:
- Macro: SERIAL_ADDER_SUBTRACT_EN.
- Defined:
  - Adds input port sub (1 bit), captured with start.
  - If sub = 1: b_sr loads ~b and carry loads 1, so sum = a - b mod 2^WIDTH and cout = 1 means no borrow (a >= b unsigned).
  - If sub = 0: identical to addition.
- Not defined: no sub port; carry always loads 0; block is add-only. Timing is identical in both builds.

Test Plan:
1. reset = 1 for 2 cycles, then idle 3 cycles, start = 0 -> busy = 0, done = 0, sum = 4'h0, cout = 0 throughout.
2. WIDTH = 4, a = 3, b = 5, one-cycle start -> busy high exactly 4 cycles, then done high 1 cycle, sum = 8, cout = 0. sum stays 8 for 10 idle cycles.
3. a = 15, b = 1 -> sum = 0, cout = 1 (wrap-around). Then a = 15, b = 15 -> sum = 14, cout = 1.
4. Start a = 2, b = 2. Pulse start with a = 7, b = 7 during RUN -> result sum = 4, cout = 0, a single done pulse, and no second operation. Then hold start high with a = 1, b = 6 -> repeated done pulses every WIDTH+2 cycles, each with sum = 7.
5. Start a = 9, b = 4. Assert reset on the 2nd RUN cycle -> busy drops next edge, no done, sum = 0, cout = 0. Then a = 9, b = 4 -> sum = 13, cout = 0.
6. With SERIAL_ADDER_SUBTRACT_EN: a = 5, b = 7, sub = 1 -> sum = 14, cout = 0. Then a = 7, b = 5, sub = 1 -> sum = 2, cout = 1. Then sub = 0, a = 7, b = 5 -> sum = 12, cout = 0.
